// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin owner selection for the shared 32-bit system bus.
// Four requesters compete; when nobody owns the bus the grant is zero and the
// default master drives it. Every ownership change passes through a one-cycle
// dead slot, and an owner is forced off after MAX_HOLD cycles if someone waits.

module dma_bus_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       bus_busy,
   output logic       hold_expired
);

   localparam int            CW        = $clog2(MAX_HOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN,
      ST_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]    grant_q, grant_d;
   logic          bus_busy_q, bus_busy_d;
   logic          hold_expired_q, hold_expired_d;

   logic          win_found;
   logic [1:0]    win_idx;
   logic [1:0]    cand;
   logic          others_pending;

   // Pick the first requester searching downward from last-1 with wrap, so the previous owner comes last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q - 2'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state logic: arbitrate from IDLE/GAP, and in OWN decide between keeping, releasing or forcing off.
   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      hold_cnt_d     = hold_cnt_q;
      grant_d        = grant_q;
      hold_expired_d = 1'b0;
      others_pending = |(req & ~grant_q);

      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (win_found) begin
               state_d    = ST_OWN;
               last_d     = win_idx;
               hold_cnt_d = '0;
               grant_d    = 4'b0001 << win_idx;
            end else begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
            end
         end
         ST_OWN: begin
            if (!req[last_q]) begin
               state_d = ST_GAP;
               grant_d = 4'b0000;
            end else if (others_pending && (hold_cnt_q == HOLD_LAST)) begin
               state_d        = ST_GAP;
               grant_d        = 4'b0000;
               hold_expired_d = 1'b1;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
         end
      endcase

      bus_busy_d = |grant_d;
   end

   // State and output registers; reset clears the grant immediately without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         last_q         <= 2'd0;
         hold_cnt_q     <= '0;
         grant_q        <= 4'b0000;
         bus_busy_q     <= 1'b0;
         hold_expired_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_q         <= last_d;
         hold_cnt_q     <= hold_cnt_d;
         grant_q        <= grant_d;
         bus_busy_q     <= bus_busy_d;
         hold_expired_q <= hold_expired_d;
      end
   end

   assign grant        = grant_q;
   assign bus_busy     = bus_busy_q;
   assign hold_expired = hold_expired_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter with MAX_HOLD=4: directed sequence with
// hand-computed grants, followed by a random-request invariant sweep.

module tb_dma_bus_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       bus_busy;
   logic       hold_expired;

   int testsRun   = 0;
   int testsFailed = 0;

   // Invariant-sweep bookkeeping
   logic [3:0] prevGrant;
   logic [3:0] reqAtEdge;
   int         runLen;
   int         prevRunLen;

   dma_bus_arbiter #(
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .bus_busy    (bus_busy),
      .hold_expired(hold_expired)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive a request vector, let one rising edge sample it, then settle 1 time unit past the edge
   task automatic applyStimulus(input logic [3:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask

   // Compare all three outputs against expectations; bus_busy must always follow the expected grant
   task automatic checkOutput(input string tag, input logic [3:0] expGrant, input logic expExpired);
      testsRun++;
      assert ({grant, bus_busy, hold_expired} === {expGrant, |expGrant, expExpired})
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: got grant=%b bus_busy=%b hold_expired=%b, expected grant=%b bus_busy=%b hold_expired=%b",
                tag, grant, bus_busy, hold_expired, expGrant, |expGrant, expExpired);
      end
   endtask

   // Single-bit property check used by the invariant sweep
   task automatic checkBit(input string tag, input logic observed, input logic expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: got %b, expected %b (grant=%b req=%b)", tag, observed, expected, grant, reqAtEdge);
      end
   endtask

   // Directed sequence followed by the random sweep, then the summary line
   initial begin
      logic [3:0] expG;
      int         owner;

      reset = 1'b0;
      req   = 4'b0000;
      #1 reset = 1'b1;
      #1;
      checkOutput("reset_values", 4'b0000, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;

      // First grant after reset: search 3,2,1,0 finds requester 2
      applyStimulus(4'b0100);
      checkOutput("first_grant", 4'b0100, 1'b0);

      // Reset mid-grant clears outputs before the next clock edge
      #3 reset = 1'b1;
      #1;
      checkOutput("async_reset", 4'b0000, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Idle with no requests for 20 cycles
      for (int i = 0; i < 20; i++) begin
         applyStimulus(4'b0000);
         checkOutput("idle_hold", 4'b0000, 1'b0);
      end

      // Full contention: owners rotate 3,2,1,0,3 with 4-cycle holds and expiry gaps
      for (int r = 0; r < 5; r++) begin
         owner = 3 - (r % 4);
         expG  = 4'b0001 << owner;
         for (int c = 0; c < MAX_HOLD; c++) begin
            applyStimulus(4'b1111);
            checkOutput("rr_own", expG, 1'b0);
         end
         applyStimulus(4'b1111);
         checkOutput("rr_gap", 4'b0000, 1'b1);
      end

      // Drop everything: GAP falls through to IDLE (last=3)
      applyStimulus(4'b0000);
      checkOutput("rr_to_idle", 4'b0000, 1'b0);

      // Lone requester keeps the bus indefinitely
      applyStimulus(4'b0010);
      checkOutput("single_grant", 4'b0010, 1'b0);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(4'b0010);
         checkOutput("single_hold", 4'b0010, 1'b0);
      end
      applyStimulus(4'b0000);
      checkOutput("single_release", 4'b0000, 1'b0);
      applyStimulus(4'b0000);
      checkOutput("single_idle", 4'b0000, 1'b0);

      // last=1: order 0,3,2,1 -> requester 3 wins
      applyStimulus(4'b1000);
      checkOutput("grant_3", 4'b1000, 1'b0);
      applyStimulus(4'b0000);
      checkOutput("release_3", 4'b0000, 1'b0);

      // Request present only during the GAP cycle is granted right after it
      applyStimulus(4'b0100);
      checkOutput("gap_request", 4'b0100, 1'b0);

      // Owner 2 releases early with 3 and 0 pending; 1 is skipped in favour of 0
      applyStimulus(4'b1101);
      checkOutput("early_own", 4'b0100, 1'b0);
      applyStimulus(4'b1001);
      checkOutput("early_release", 4'b0000, 1'b0);
      applyStimulus(4'b1001);
      checkOutput("rotation_skip", 4'b0001, 1'b0);

      // Owner 0 releases exactly at the hold limit: counts as normal release
      for (int c = 1; c < MAX_HOLD; c++) begin
         applyStimulus(4'b1001);
         checkOutput("coincide_own", 4'b0001, 1'b0);
      end
      applyStimulus(4'b1000);
      checkOutput("coincide_release", 4'b0000, 1'b0);
      applyStimulus(4'b1000);
      checkOutput("coincide_next", 4'b1000, 1'b0);
      applyStimulus(4'b0000);
      checkOutput("coincide_drop", 4'b0000, 1'b0);
      applyStimulus(4'b0000);
      checkOutput("coincide_idle", 4'b0000, 1'b0);

      // Lone owner saturates its counter; a late competitor forces it off at once
      applyStimulus(4'b0010);
      checkOutput("sat_grant", 4'b0010, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'b0010);
         checkOutput("sat_hold", 4'b0010, 1'b0);
      end
      applyStimulus(4'b0011);
      checkOutput("sat_expiry", 4'b0000, 1'b1);
      applyStimulus(4'b0001);
      checkOutput("sat_next", 4'b0001, 1'b0);

      // Random requests: check one-hot, busy flag, dead slot and hold limit every cycle
      prevGrant = grant;
      runLen    = 1;
      for (int i = 0; i < 3000; i++) begin
         reqAtEdge  = 4'($urandom_range(0, 15));
         prevRunLen = runLen;
         applyStimulus(reqAtEdge);
         checkBit("inv_onehot0", $onehot0(grant), 1'b1);
         checkBit("inv_busy", bus_busy, |grant);
         if (hold_expired) begin
            checkBit("inv_expired_gap", |grant, 1'b0);
         end
         if (prevGrant != 4'b0000 && grant != 4'b0000) begin
            checkBit("inv_no_switch", grant == prevGrant, 1'b1);
         end
         if (prevGrant != 4'b0000 && prevRunLen >= MAX_HOLD &&
             (reqAtEdge & prevGrant) != 4'b0000 && (reqAtEdge & ~prevGrant) != 4'b0000) begin
            checkBit("inv_hold_limit", |grant, 1'b0);
            checkBit("inv_hold_pulse", hold_expired, 1'b1);
         end
         if (grant != 4'b0000 && grant == prevGrant) begin
            runLen = runLen + 1;
         end else if (grant != 4'b0000) begin
            runLen = 1;
         end else begin
            runLen = 0;
         end
         prevGrant = grant;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
